node_port: RTL and testbench

- Node-side endpoint of the router's node link. It is the opposite end of the router's byte-serial port.
- TX path: buffers 32-bit packets from the node core in a small FIFO and serialises each one onto the link as 4 bytes, MS byte first, gated by the router's free flag.
- RX path: deserialises 4-byte bursts from the router into a 32-bit holding register and hands each packet to the node core with a valid/ready handshake.
- Advertises its own free flag to the router.

---
 rtl/node_port_if.sv | 30 +++
 rtl/node_port.sv | 164 ++++++++++++++++
 tb/tb_node_port.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/node_port_if.sv
// Node-core and router-link signals of node_port, bundled for port connection.
// The slave modport is the node_port view; master is the environment driving it.
interface node_port_if #(
   parameter int TX_DEPTH = 4
);
   logic [31:0]               tx_data;
   logic                      tx_valid;
   logic                      tx_ready;
   logic [$clog2(TX_DEPTH):0] tx_count;
   logic                      router_free;
   logic                      node_put;
   logic [7:0]                node_payload;
   logic                      router_put;
   logic [7:0]                router_payload;
   logic                      node_free;
   logic [31:0]               rx_data;
   logic                      rx_valid;
   logic                      rx_ready;
   logic                      rx_err;

   modport master (
      output tx_data, tx_valid, router_free, router_put, router_payload, rx_ready,
      input  tx_ready, tx_count, node_put, node_payload, node_free, rx_data, rx_valid, rx_err
   );

   modport slave (
      input  tx_data, tx_valid, router_free, router_put, router_payload, rx_ready,
      output tx_ready, tx_count, node_put, node_payload, node_free, rx_data, rx_valid, rx_err
   );
endinterface

// File: rtl/node_port.sv
// Node-side endpoint of the router byte link: TX FIFO + 4-byte serialiser,
// RX 4-byte deserialiser with a single holding register and valid/ready hand-off.
module node_port #(
   parameter int TX_DEPTH = 4
) (
   input logic        clock,
   input logic        reset,
   node_port_if.slave bus
);
   localparam int AW = $clog2(TX_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {T_IDLE, T_SEND} tx_state_t;
   typedef enum logic {R_IDLE, R_RECV} rx_state_t;

   // ---------------- TX FIFO ----------------
   logic [31:0]   mem [TX_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          push, pop;

   assign bus.tx_ready = (count < CW'(TX_DEPTH));
   assign bus.tx_count = count;
   assign push         = bus.tx_valid && bus.tx_ready;

   // NOTE: storage has no reset; emptiness is tracked by count alone.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= bus.tx_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // ---------------- TX serialiser ----------------
   tx_state_t   tx_state, tx_next;
   logic [1:0]  tx_idx;
   logic [31:0] tx_shift;
   logic        put_q;
   logic [7:0]  payload_q;

   // NOTE: every comb output gets a default first so no latch is inferred.
   always_comb begin
      tx_next = tx_state;
      pop     = 1'b0;
      case (tx_state)
         T_IDLE: if (count != '0 && bus.router_free) begin
            tx_next = T_SEND;
            pop     = 1'b1;
         end
         T_SEND: if (tx_idx == 2'd3) tx_next = T_IDLE;
         default: tx_next = T_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) tx_state <= T_IDLE;
      else       tx_state <= tx_next;
   end

   // tx_idx counts bytes already on the line; the 4th byte ends the burst.
   always_ff @(posedge clock) begin
      if (reset) begin
         tx_idx    <= '0;
         tx_shift  <= '0;
         put_q     <= 1'b0;
         payload_q <= '0;
      end else if (pop) begin
         tx_idx    <= '0;
         put_q     <= 1'b1;
         payload_q <= mem[rd_ptr][31:24];
         tx_shift  <= {mem[rd_ptr][23:0], 8'h00};
      end else if (tx_state == T_SEND) begin
         if (tx_idx == 2'd3) begin
            put_q     <= 1'b0;
            payload_q <= '0;
         end else begin
            tx_idx    <= tx_idx + 2'd1;
            payload_q <= tx_shift[31:24];
            tx_shift  <= {tx_shift[23:0], 8'h00};
         end
      end
   end

   assign bus.node_put     = put_q;
   assign bus.node_payload = payload_q;

   // ---------------- RX deserialiser ----------------
   rx_state_t   rx_state, rx_next;
   logic [1:0]  rx_idx;
   logic [23:0] rx_acc;
   logic        hold_valid;
   logic [31:0] hold;
   logic        start, load, err;

   assign bus.node_free = (rx_state == R_IDLE) && !hold_valid;

   always_comb begin
      rx_next = rx_state;
      start   = 1'b0;
      load    = 1'b0;
      err     = 1'b0;
      case (rx_state)
         R_IDLE: if (bus.router_put) begin
            if (hold_valid) begin
               err = 1'b1;
            end else begin
               start   = 1'b1;
               rx_next = R_RECV;
            end
         end
         R_RECV: if (!bus.router_put) begin
            err     = 1'b1;
            rx_next = R_IDLE;
         end else if (rx_idx == 2'd2) begin
            load    = 1'b1;
            rx_next = R_IDLE;
         end
         default: rx_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) rx_state <= R_IDLE;
      else       rx_state <= rx_next;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_idx     <= '0;
         rx_acc     <= '0;
         hold_valid <= 1'b0;
         hold       <= '0;
      end else begin
         if (start) begin
            rx_idx <= '0;
            rx_acc <= {16'h0000, bus.router_payload};
         end else if (rx_state == R_RECV && bus.router_put && !load) begin
            rx_idx <= rx_idx + 2'd1;
            rx_acc <= {rx_acc[15:0], bus.router_payload};
         end
         if (load) begin
            hold       <= {rx_acc, bus.router_payload};
            hold_valid <= 1'b1;
         end else if (hold_valid && bus.rx_ready) begin
            hold_valid <= 1'b0;
         end
      end
   end

   assign bus.rx_data  = hold;
   assign bus.rx_valid = hold_valid;
   // An abort by reset is silent, even mid-burst.
   assign bus.rx_err   = err && !reset;
endmodule

// File: tb/tb_node_port.sv
// Randomised self-checking bench for node_port against a queue-based packet model.
// Inputs change at the falling edge; outputs are sampled 2 time units later.
module tb_node_port;
   localparam int DEPTH = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   node_port_if #(.TX_DEPTH(DEPTH)) bus ();

   node_port #(.TX_DEPTH(DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   // Observed traffic, rebuilt from the link by a passive monitor.
   logic [31:0] tx_seen [$];
   logic [31:0] rx_seen [$];
   int          err_pulses = 0;
   logic [31:0] mon_word   = '0;
   int          mon_nb     = 0;
   bit          mon_gap    = 1'b0;
   bit          prev_valid = 1'b0;
   bit          prev_taken = 1'b0;
   logic [31:0] prev_data  = '0;

   always begin
      @(negedge clock);
      #2;
      if (reset) begin
         mon_nb     = 0;
         mon_gap    = 1'b0;
         prev_valid = 1'b0;
      end else begin
         if (bus.node_put) begin
            total++;
            if (mon_gap) begin
               bad++;
               $display("FAIL tx_gap: node_put=1 required 0 in the cycle after a burst");
            end
            mon_word = {mon_word[23:0], bus.node_payload};
            mon_nb++;
            mon_gap = 1'b0;
            if (mon_nb == 4) begin
               tx_seen.push_back(mon_word);
               mon_nb  = 0;
               mon_gap = 1'b1;
            end
         end else begin
            total++;
            if (bus.node_payload !== 8'h00 || mon_nb != 0) begin
               bad++;
               $display("FAIL tx_idle: payload=%h bytes_pending=%0d required 00 and 0",
                        bus.node_payload, mon_nb);
            end
            mon_nb  = 0;
            mon_gap = 1'b0;
         end
         if (prev_valid && !prev_taken) begin
            total++;
            if (bus.rx_valid !== 1'b1 || bus.rx_data !== prev_data) begin
               bad++;
               $display("FAIL rx_hold: valid=%b data=%h required 1 %h",
                        bus.rx_valid, bus.rx_data, prev_data);
            end
         end
         if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) rx_seen.push_back(bus.rx_data);
         if (bus.rx_err === 1'b1) err_pulses++;
         prev_valid = (bus.rx_valid === 1'b1);
         prev_taken = (bus.rx_ready === 1'b1);
         prev_data  = bus.rx_data;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_idle();
      bus.tx_valid       = 1'b0;
      bus.tx_data        = '0;
      bus.router_free    = 1'b0;
      bus.router_put     = 1'b0;
      bus.router_payload = '0;
      bus.rx_ready       = 1'b0;
   endtask

   function automatic logic [7:0] byte_of(logic [31:0] w, int i);
      return 8'((w >> (24 - 8 * i)) & 32'hFF);
   endfunction

   task automatic test_reset();
      logic [50:0] got;
      reset = 1'b1;
      drive_idle();
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #2;
      got = {bus.tx_ready, bus.tx_count, bus.node_put, bus.node_payload, bus.node_free,
             bus.rx_valid, bus.rx_data, bus.rx_err};
      total++;
      if (got !== {1'b1, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0}) begin
         bad++;
         $display("FAIL reset_outputs: got=%h required ready=1 count=0 put=0 payload=0 free=1 valid=0 data=0 err=0", got);
      end
   endtask

   task automatic test_single_tx();
      logic [31:0] pkt = 32'hA1B2C3D4;
      tx_seen.delete();
      bus.router_free = 1'b1;
      @(negedge clock);
      bus.tx_valid = 1'b1;
      bus.tx_data  = pkt;
      @(negedge clock);
      bus.tx_valid = 1'b0;
      #2;
      total++;
      if (bus.node_put !== 1'b0 || bus.tx_count !== 3'd1) begin
         bad++;
         $display("FAIL tx_latency: put=%b count=%0d required 0 1", bus.node_put, bus.tx_count);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         #2;
         total++;
         if (bus.node_put !== 1'b1 || bus.node_payload !== byte_of(pkt, i)) begin
            bad++;
            $display("FAIL tx_byte%0d: put=%b payload=%h required 1 %h",
                     i, bus.node_put, bus.node_payload, byte_of(pkt, i));
         end
      end
      @(negedge clock);
      #2;
      total++;
      if (bus.node_put !== 1'b0 || bus.tx_count !== 3'd0 || tx_seen.size() != 1) begin
         bad++;
         $display("FAIL tx_end: put=%b count=%0d packets=%0d required 0 0 1",
                  bus.node_put, bus.tx_count, tx_seen.size());
      end
      bus.router_free = 1'b0;
   endtask

   task automatic test_fifo_full();
      logic [31:0] expq [$];
      logic [31:0] d;
      int          occ = 0;
      int          budget;
      tx_seen.delete();
      bus.router_free = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         d            = $urandom;
         bus.tx_valid = 1'b1;
         bus.tx_data  = d;
         #2;
         total++;
         if (bus.tx_ready !== (occ < DEPTH)) begin
            bad++;
            $display("FAIL fifo_ready%0d: ready=%b required %b", i, bus.tx_ready, occ < DEPTH);
         end
         if (occ < DEPTH) begin
            expq.push_back(d);
            occ++;
         end
      end
      @(negedge clock);
      bus.tx_valid = 1'b0;
      #2;
      total++;
      if (bus.tx_count !== 3'(DEPTH) || bus.tx_ready !== 1'b0) begin
         bad++;
         $display("FAIL fifo_full: count=%0d ready=%b required %0d 0", bus.tx_count, bus.tx_ready, DEPTH);
      end
      @(negedge clock);
      bus.router_free = 1'b1;
      budget = 0;
      while (tx_seen.size() < expq.size() && budget < 60) begin
         @(negedge clock);
         budget++;
      end
      repeat (8) @(negedge clock);
      #2;
      total++;
      if (tx_seen.size() != expq.size() || bus.tx_count !== 3'd0) begin
         bad++;
         $display("FAIL fifo_drain: packets=%0d count=%0d required %0d 0",
                  tx_seen.size(), bus.tx_count, expq.size());
      end
      for (int i = 0; i < expq.size() && i < tx_seen.size(); i++) begin
         total++;
         if (tx_seen[i] !== expq[i]) begin
            bad++;
            $display("FAIL fifo_order%0d: got=%h required %h", i, tx_seen[i], expq[i]);
         end
      end
      bus.router_free = 1'b0;
   endtask

   task automatic test_rx_overrun();
      logic [31:0] pkt = 32'h12345678;
      int          e0;
      rx_seen.delete();
      bus.rx_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         bus.router_put     = 1'b1;
         bus.router_payload = byte_of(pkt, i);
      end
      @(negedge clock);
      bus.router_put = 1'b0;
      #2;
      total++;
      if (bus.rx_valid !== 1'b1 || bus.rx_data !== pkt || bus.node_free !== 1'b0) begin
         bad++;
         $display("FAIL rx_full: valid=%b data=%h free=%b required 1 %h 0",
                  bus.rx_valid, bus.rx_data, bus.node_free, pkt);
      end
      e0 = err_pulses;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         bus.router_put     = 1'b1;
         bus.router_payload = 8'($urandom);
         #2;
         total++;
         if (bus.rx_err !== 1'b1) begin
            bad++;
            $display("FAIL rx_overrun%0d: err=%b required 1", i, bus.rx_err);
         end
      end
      @(negedge clock);
      bus.router_put = 1'b0;
      bus.rx_ready   = 1'b1;
      #2;
      total++;
      if (bus.rx_err !== 1'b0 || bus.rx_valid !== 1'b1 || bus.rx_data !== pkt) begin
         bad++;
         $display("FAIL rx_keep: err=%b valid=%b data=%h required 0 1 %h",
                  bus.rx_err, bus.rx_valid, bus.rx_data, pkt);
      end
      @(negedge clock);
      bus.rx_ready = 1'b0;
      #2;
      total++;
      if (bus.node_free !== 1'b1 || bus.rx_valid !== 1'b0 || err_pulses - e0 != 4 ||
          rx_seen.size() != 1) begin
         bad++;
         $display("FAIL rx_release: free=%b valid=%b errs=%0d packets=%0d required 1 0 4 1",
                  bus.node_free, bus.rx_valid, err_pulses - e0, rx_seen.size());
      end else begin
         total++;
         if (rx_seen[0] !== pkt) begin
            bad++;
            $display("FAIL rx_value: got=%h required %h", rx_seen[0], pkt);
         end
      end
   endtask

   task automatic test_rx_framing();
      logic [31:0] pkt = 32'h01020304;
      int          e0  = err_pulses;
      rx_seen.delete();
      bus.rx_ready = 1'b1;
      @(negedge clock);
      bus.router_put     = 1'b1;
      bus.router_payload = 8'hDE;
      @(negedge clock);
      bus.router_payload = 8'hAD;
      @(negedge clock);
      bus.router_put = 1'b0;
      #2;
      total++;
      if (bus.rx_err !== 1'b1 || bus.rx_valid !== 1'b0) begin
         bad++;
         $display("FAIL frame_err: err=%b valid=%b required 1 0", bus.rx_err, bus.rx_valid);
      end
      @(negedge clock);
      #2;
      total++;
      if (bus.rx_err !== 1'b0 || bus.rx_valid !== 1'b0 || bus.node_free !== 1'b1) begin
         bad++;
         $display("FAIL frame_recover: err=%b valid=%b free=%b required 0 0 1",
                  bus.rx_err, bus.rx_valid, bus.node_free);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         bus.router_put     = 1'b1;
         bus.router_payload = byte_of(pkt, i);
      end
      @(negedge clock);
      bus.router_put = 1'b0;
      repeat (2) @(negedge clock);
      total++;
      if (rx_seen.size() != 1 || err_pulses - e0 != 1) begin
         bad++;
         $display("FAIL frame_next: packets=%0d errs=%0d required 1 1", rx_seen.size(), err_pulses - e0);
      end else begin
         total++;
         if (rx_seen[0] !== pkt) begin
            bad++;
            $display("FAIL frame_value: got=%h required %h", rx_seen[0], pkt);
         end
      end
      bus.rx_ready = 1'b0;
   endtask

   task automatic test_concurrent();
      logic [31:0] tx_exp [$];
      logic [31:0] rx_exp [$];
      int          e0 = err_pulses;
      int          budget;
      tx_seen.delete();
      rx_seen.delete();
      bus.rx_ready = 1'b1;
      fork
         begin
            logic [31:0] d;
            int          wait_cnt;
            for (int p = 0; p < 6; p++) begin
               d = (p == 0) ? 32'hCAFEF00D : 32'($urandom);
               @(negedge clock);
               bus.tx_valid    = 1'b1;
               bus.tx_data     = d;
               bus.router_free = 1'($urandom);
               #1;
               wait_cnt = 0;
               while (bus.tx_ready !== 1'b1 && wait_cnt < 50) begin
                  @(negedge clock);
                  bus.router_free = 1'($urandom);
                  #1;
                  wait_cnt++;
               end
               tx_exp.push_back(d);
            end
            @(negedge clock);
            bus.tx_valid    = 1'b0;
            bus.router_free = 1'b1;
         end
         begin
            logic [31:0] r;
            int          gap;
            for (int p = 0; p < 6; p++) begin
               r = (p == 0) ? 32'h0BADBEEF : 32'($urandom);
               for (int i = 0; i < 4; i++) begin
                  @(negedge clock);
                  bus.router_put     = 1'b1;
                  bus.router_payload = byte_of(r, i);
               end
               rx_exp.push_back(r);
               gap = (p == 0) ? 1 : int'($urandom_range(1, 3));
               for (int g = 0; g < gap; g++) begin
                  @(negedge clock);
                  bus.router_put = 1'b0;
               end
            end
         end
      join
      budget = 0;
      while ((tx_seen.size() < tx_exp.size() || rx_seen.size() < rx_exp.size()) && budget < 100) begin
         @(negedge clock);
         budget++;
      end
      repeat (3) @(negedge clock);
      total++;
      if (tx_seen.size() != tx_exp.size() || rx_seen.size() != rx_exp.size() || err_pulses != e0) begin
         bad++;
         $display("FAIL conc_counts: tx=%0d rx=%0d errs=%0d required %0d %0d 0",
                  tx_seen.size(), rx_seen.size(), err_pulses - e0, tx_exp.size(), rx_exp.size());
      end
      for (int i = 0; i < tx_exp.size() && i < tx_seen.size(); i++) begin
         total++;
         if (tx_seen[i] !== tx_exp[i]) begin
            bad++;
            $display("FAIL conc_tx%0d: got=%h required %h", i, tx_seen[i], tx_exp[i]);
         end
      end
      for (int i = 0; i < rx_exp.size() && i < rx_seen.size(); i++) begin
         total++;
         if (rx_seen[i] !== rx_exp[i]) begin
            bad++;
            $display("FAIL conc_rx%0d: got=%h required %h", i, rx_seen[i], rx_exp[i]);
         end
      end
      bus.router_free = 1'b0;
      bus.rx_ready    = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [50:0] got;
      tx_seen.delete();
      rx_seen.delete();
      bus.router_free = 1'b1;
      bus.rx_ready    = 1'b1;
      @(negedge clock);
      bus.tx_valid = 1'b1;
      bus.tx_data  = $urandom;
      @(negedge clock);
      bus.tx_data  = $urandom;
      @(negedge clock);
      bus.tx_valid       = 1'b0;
      bus.router_put     = 1'b1;
      bus.router_payload = 8'($urandom);
      @(negedge clock);
      bus.router_payload = 8'($urandom);
      #2;
      total++;
      if (bus.node_put !== 1'b1) begin
         bad++;
         $display("FAIL mid_setup: node_put=%b required 1", bus.node_put);
      end
      @(negedge clock);
      reset              = 1'b1;
      bus.router_payload = 8'($urandom);
      @(negedge clock);
      reset          = 1'b0;
      bus.router_put = 1'b0;
      #2;
      got = {bus.tx_ready, bus.tx_count, bus.node_put, bus.node_payload, bus.node_free,
             bus.rx_valid, bus.rx_data, bus.rx_err};
      total++;
      if (got !== {1'b1, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0}) begin
         bad++;
         $display("FAIL mid_reset_outputs: got=%h required ready=1 count=0 put=0 payload=0 free=1 valid=0 data=0 err=0", got);
      end
      repeat (12) @(negedge clock);
      total++;
      if (tx_seen.size() != 0 || rx_seen.size() != 0) begin
         bad++;
         $display("FAIL mid_no_resend: tx=%0d rx=%0d required 0 0", tx_seen.size(), rx_seen.size());
      end
      bus.router_free = 1'b0;
      bus.rx_ready    = 1'b0;
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_single_tx();
      test_fifo_full();
      test_rx_overrun();
      test_rx_framing();
      test_concurrent();
      test_reset_mid();
      repeat (2) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
